regfile_dump: RTL and testbench
===============================

Name: regfile_dump

Overview:
- Sequential read-side client of the 32x64 register file: on a start pulse, walks read port addresses 0..NREGS-1 and streams {index, value} words out over a valid/ready handshake.
- Sits beside the datapath on a spare register-file read port.
- Feeds the debug/UART path, so software-visible register state can be dumped after a program halts.

Parameters:
- NREGS, 32, number of registers walked (indices 0..NREGS-1)
- AW, 5, register address width
- DW, 64, register data width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a dump; sampled only in IDLE
- ra  output  AW  read address driven to the register-file read port
- rd  input  DW  combinational read data returned for ra
- out_valid  output  1  out_idx/out_data hold a valid word
- out_ready  input  1  consumer accepts the word this cycle
- out_idx  output  AW  register index of the current word
- out_data  output  DW  register value of the current word
- busy  output  1  dump in progress (any state other than IDLE)
- done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Synchronous reset, active-high; no asynchronous paths.
- Reset values: state=IDLE, ra=0, out_valid=0, out_idx=0, out_data=0, busy=0, done=0.
- ra is driven from a registered counter idx. rd is treated as combinationally valid in the cycle after ra changes.
- FSM states: IDLE, READ, SEND, FIN.
  - IDLE: if start=1, idx<=0 and go to READ; otherwise stay. done=0.
  - READ: out_data<=rd, out_idx<=idx, out_valid<=1, go to SEND.
  - SEND: out_valid=1; out_idx/out_data held stable while out_ready=0.
    - On out_valid&&out_ready with idx==NREGS-1: out_valid<=0, go to FIN.
    - On out_valid&&out_ready otherwise: idx<=idx+1, out_valid<=0, go to READ.
  - FIN: done=1 for exactly one cycle, then IDLE.
- Latency:
  - start to first out_valid: 2 cycles (IDLE->READ->SEND).
  - With out_ready held at 1, one word every 2 cycles; a full dump of 32 words takes 64 cycles plus the FIN cycle.
- Handshake rules:
  - out_valid never drops without acceptance.
  - out_data and out_idx never change while out_valid=1 and out_ready=0.
- start while busy=1 is ignored; it neither restarts nor queues a dump.
- start in the FIN cycle is ignored. A start in the cycle after done is accepted.
- reset mid-dump (any state): next cycle is IDLE with all outputs at reset values. No done pulse; the partial dump is abandoned.
- idx arithmetic is AW bits. Termination compares idx to NREGS-1, so idx never wraps past the last index.
- The block never writes the register file and drives no write-port signals.

Optional Feature:
- Macro: REGDUMP_SKIP_ZERO_EN.
- Defined: in READ, if rd==0 the word is not presented.
  - If idx==NREGS-1, go to FIN; otherwise idx<=idx+1 and stay in READ.
  - Each skipped register costs one cycle; only nonzero registers appear on the stream.
  - done still pulses exactly once per dump, including when all registers are zero (zero words emitted).
- Undefined: every register 0..NREGS-1 is emitted, zero or not, as described above.

Test Plan:
- Full dump, no backpressure: register model preloaded Xi=i for i=0..30, X31=0; pulse start with out_ready=1.
  - Required: 32 words in order, idx 0..31, data 0..30 then 0.
  - First out_valid 2 cycles after start; done one cycle after word 31 is accepted; busy low the cycle after done.
- Backpressure: same preload; hold out_ready=0 for 5 cycles while word idx=3 (data 3) is valid.
  - Required: out_valid stays 1 and out_idx/out_data hold 3/3 for all 5 cycles.
  - Word 4 follows 2 cycles after the accept.
- Start while busy: pulse start again at word idx=10.
  - Required: the dump continues uninterrupted to idx=31, exactly one done pulse, no second dump.
- Reset mid-dump: assert reset for 1 cycle while in SEND at idx=7.
  - Required: next cycle out_valid=0, busy=0, ra=0, done=0.
  - A new start produces a full dump from idx 0.
- Back-to-back dumps: pulse start the cycle after done.
  - Required: the second dump begins, first out_valid 2 cycles later, idx 0.
- REGDUMP_SKIP_ZERO_EN defined: preload X0=0, X5=0xDEADBEEF, X31=0, all others 0; pulse start.
  - Required: exactly one word (idx=5, data 0xDEADBEEF), then a single done pulse.
  - With all registers zero: no words, done pulse ~33 cycles after start.

Source files
------------

// File: rtl/regfile_dump.sv
// regfile_dump -- sequential dump client for a spare register-file read port.
//
// On a start pulse (honoured only when idle) the block walks read addresses
// 0..NREGS-1 and streams one {index, value} word per register over a
// valid/ready handshake, then pulses done for one cycle. It never writes the
// register file.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      single-cycle request to begin a dump (ignored unless idle)
//   ra         read address to the register-file read port
//   rd         combinational read data for ra
//   out_valid  out_idx/out_data hold a valid word
//   out_ready  consumer accepts the word this cycle
//   out_idx    register index of the current word
//   out_data   register value of the current word
//   busy       dump in progress (any state other than IDLE)
//   done       one-cycle pulse after the last word is accepted
//
// Build option:
//   REGDUMP_SKIP_ZERO_EN  when defined, registers reading zero are skipped
//                         (one cycle each) and never appear on the stream.

module regfile_dump #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] ra,
    input  logic [DW-1:0] rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_idx,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } word_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t        state, state_d;
    logic [AW-1:0] idx, idx_d;
    word_t         word, word_d;
    logic          last;
    logic          skip;

    // Termination is an equality test on the last index, so idx never
    // needs to wrap.
    assign last = (idx == LAST);

`ifdef REGDUMP_SKIP_ZERO_EN
    assign skip = (rd == '0);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            word  <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            word  <= word_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        word_d  = word;
        case (state)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                // rd is valid this cycle for the address registered last cycle.
                if (skip) begin
                    if (last) state_d = FIN;
                    else      idx_d   = idx + AW'(1);
                end else begin
                    word_d.idx  = idx;
                    word_d.data = rd;
                    state_d     = SEND;
                end
            end
            SEND: begin
                // Word stays frozen in the holding register until accepted.
                if (out_ready) begin
                    if (last) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx + AW'(1);
                        state_d = READ;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Valid/busy/done decode straight from the state register, so they can
    // never disagree with the FSM.
    assign ra        = idx;
    assign out_valid = (state == SEND);
    assign out_idx   = word.idx;
    assign out_data  = word.data;
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;

    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int DW    = 64;

    typedef struct {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_idx;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [NREGS];
    exp_t          exp_q [$];
    int            n_chk = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            acc_last_cyc = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rd = regs[ra];

    regfile_dump #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .ra(ra), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_data(out_data), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected stream for one dump of the current register model.
    task automatic push_dump();
        exp_t e;
        for (int i = 0; i < NREGS; i++) begin
`ifdef REGDUMP_SKIP_ZERO_EN
            if (regs[i] == '0) continue;
`endif
            e.idx  = AW'(i);
            e.data = regs[i];
            exp_q.push_back(e);
        end
    endtask

    // Pulse start for one cycle; returns the cycle in which start was high.
    task automatic pulse_start(output int st);
        push_dump();
        st    = cyc;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        int n = 0;
        dc = -1;
        while (!done && n < budget) begin
            tick(1);
            n++;
        end
        if (done) dc = cyc;
        else      chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_word(input int idx, input int budget);
        int n = 0;
        while (!(out_valid && out_idx == AW'(idx)) && n < budget) begin
            tick(1);
            n++;
        end
        chk("word_reached", {63'd0, out_valid && out_idx == AW'(idx)}, 64'd1);
    endtask

    // Scoreboard: every accepted word is matched against the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {59'd0, out_idx}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word_idx", {59'd0, out_idx}, {59'd0, e.idx});
                    chk("word_data", out_data, e.data);
                end
                if (out_idx == AW'(NREGS - 1)) acc_last_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired (cyc %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int st, dc, d0;
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NREGS; i++) regs[i] = '0;
        tick(2);
        reset = 1'b0;

        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy",  {63'd0, busy},      64'd0);
        chk("rst_done",  {63'd0, done},      64'd0);
        chk("rst_ra",    {59'd0, ra},        64'd0);
        chk("rst_idx",   {59'd0, out_idx},   64'd0);
        chk("rst_data",  out_data,           64'd0);
        tick(1);

`ifdef REGDUMP_SKIP_ZERO_EN
        regs[5] = 64'hDEAD_BEEF;
        d0 = done_cnt;
        pulse_start(st);
        wait_done(100, dc);
        tick(1);
        chk("skip_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("skip_done_once", 64'(done_cnt - d0), 64'd1);

        regs[5] = '0;
        tick(2);
        d0 = done_cnt;
        pulse_start(st);
        wait_done(100, dc);
        chk("zero_done_lat", 64'(dc - st), 64'd33);
        tick(1);
        chk("zero_done_once", 64'(done_cnt - d0), 64'd1);
        chk("zero_busy_after", {63'd0, busy}, 64'd0);
`else
        for (int i = 0; i < NREGS - 1; i++) regs[i] = DW'(i);
        regs[NREGS-1] = '0;

        // Full dump, no backpressure.
        d0 = done_cnt;
        pulse_start(st);
        chk("lat_read_valid", {63'd0, out_valid}, 64'd0);
        chk("lat_read_busy",  {63'd0, busy},      64'd1);
        tick(1);
        chk("lat_first_valid", {63'd0, out_valid}, 64'd1);
        chk("lat_first_idx",   {59'd0, out_idx},   64'd0);
        wait_done(200, dc);
        chk("dump_len", 64'(dc - st), 64'd65);
        chk("done_after_last", 64'(dc - acc_last_cyc), 64'd1);
        tick(1);
        chk("busy_after_done", {63'd0, busy}, 64'd0);
        chk("done_pulse_once", 64'(done_cnt - d0), 64'd1);
        chk("full_queue_empty", 64'(exp_q.size()), 64'd0);
        tick(2);

        // Backpressure on word 3, then a stray start at word 10.
        d0 = done_cnt;
        pulse_start(st);
        wait_word(3, 40);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_idx",   {59'd0, out_idx},   64'd3);
            chk("bp_data",  out_data,           64'd3);
            tick(1);
        end
        out_ready = 1'b1;
        tick(1);
        chk("bp_gap", {63'd0, out_valid}, 64'd0);
        tick(1);
        chk("bp_next_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_next_idx",   {59'd0, out_idx},   64'd4);
        wait_word(10, 40);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(200, dc);
        tick(10);
        chk("busy_start_one_done", 64'(done_cnt - d0), 64'd1);
        chk("busy_start_idle",     {63'd0, busy},      64'd0);
        chk("busy_queue_empty",    64'(exp_q.size()),  64'd0);

        // Reset while presenting word 7.
        pulse_start(st);
        wait_word(7, 40);
        out_ready = 1'b0;
        reset     = 1'b1;
        d0        = done_cnt;
        tick(1);
        reset = 1'b0;
        exp_q.delete();
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_busy",  {63'd0, busy},      64'd0);
        chk("midrst_ra",    {59'd0, ra},        64'd0);
        chk("midrst_done",  {63'd0, done},      64'd0);
        out_ready = 1'b1;
        tick(3);
        chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        pulse_start(st);
        tick(1);
        chk("restart_idx", {59'd0, out_idx}, 64'd0);
        wait_done(200, dc);
        // Hold start through FIN and the following idle cycle: only the
        // idle-cycle sample may launch the next dump.
        d0    = done_cnt;
        push_dump();
        start = 1'b1;
        tick(1);
        chk("restart_queue", 64'(exp_q.size()), 64'd32);
        st = cyc;
        tick(1);
        start = 1'b0;
        chk("b2b_read_valid", {63'd0, out_valid}, 64'd0);
        tick(1);
        chk("b2b_first_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_first_idx",   {59'd0, out_idx},   64'd0);
        wait_done(200, dc);
        chk("b2b_len", 64'(dc - st), 64'd65);
        tick(3);
        chk("b2b_done_cnt", 64'(done_cnt - d0), 64'd2);
        chk("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
